// File: rtl/serial_sum_splitter.sv
// Bit-serial inverse of the half-adder-chain adder: recovers b = r - a, LSB first.
// Optional macro SPLIT_RECHECK_EN adds a 'match' output that re-adds a + b and compares it with r.
module serial_sum_splitter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] b,
`ifdef SPLIT_RECHECK_EN
  output logic             match,
`endif
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           borrow;
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] d_reg;

  logic           hs1_d;
  logic           hs1_b;
  logic           hs2_d;
  logic           hs2_b;
  logic           borrow_next;
  logic [WIDTH:0] diff_next;

  // Two cascaded half subtractors, the mirror image of the adder's half-adder pair.
  always_comb begin
    hs1_d       = r_sh[0] ^ a_sh[0];
    hs1_b       = ~r_sh[0] & a_sh[0];
    hs2_d       = hs1_d ^ borrow;
    hs2_b       = ~hs1_d & borrow;
    borrow_next = hs1_b | hs2_b;
    diff_next   = {hs2_d, d_reg[WIDTH:1]};
  end

`ifdef SPLIT_RECHECK_EN
  logic [WIDTH:0]   r_lat;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] resum;
  logic             recarry;
  logic             ha1_s;
  logic             ha1_c;
  logic             ha2_c;

  // Recheck adder fed from the final difference so match lands in the same cycle as done.
  always_comb begin
    resum   = '0;
    recarry = 1'b0;
    ha1_s   = 1'b0;
    ha1_c   = 1'b0;
    ha2_c   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      ha1_s    = a_lat[i] ^ diff_next[i];
      ha1_c    = a_lat[i] & diff_next[i];
      resum[i] = ha1_s ^ recarry;
      ha2_c    = ha1_s & recarry;
      recarry  = ha1_c | ha2_c;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      borrow <= 1'b0;
      r_sh   <= '0;
      a_sh   <= '0;
      d_reg  <= '0;
      b      <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SPLIT_RECHECK_EN
      r_lat  <= '0;
      a_lat  <= '0;
      match  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            r_sh   <= r;
            a_sh   <= {1'b0, a};
            borrow <= 1'b0;
            cnt    <= '0;
            d_reg  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SPLIT_RECHECK_EN
            r_lat  <= r;
            a_lat  <= a;
            match  <= 1'b0;
`endif
          end
        end

        RUN: begin
          borrow <= borrow_next;
          d_reg  <= diff_next;
          r_sh   <= r_sh >> 1;
          a_sh   <= a_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH)) begin
            state <= DONE;
            done  <= 1'b1;
            b     <= diff_next[WIDTH-1:0];
            err   <= borrow_next | diff_next[WIDTH];
`ifdef SPLIT_RECHECK_EN
            match <= ({recarry, resum} == r_lat) & ~(borrow_next | diff_next[WIDTH]);
`endif
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sum_splitter.sv
// Self-checking bench for serial_sum_splitter: directed and random operations against an
// arithmetic reference model, plus busy-start, held-start and mid-run reset scenarios.
module tb_serial_sum_splitter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] r;
  logic [3:0] a;
  logic       busy;
  logic       done;
  logic [3:0] b;
  logic       err;
`ifdef SPLIT_RECHECK_EN
  logic       match;
`endif

  int n_checks;
  int n_fail;

  serial_sum_splitter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .r     (r),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .b     (b),
`ifdef SPLIT_RECHECK_EN
    .match (match),
`endif
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction; result must fit in 0..15 to be error-free.
  function automatic void model(input int rv, input int av, output logic [3:0] eb, output logic ee);
    int d;
    d  = rv - av;
    eb = 4'(d & 15);
    ee = (d < 0) || (d > 15);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 20);
  endtask

  // One full operation; operands are scrambled right after acceptance to prove they are latched.
  task automatic applyStimulus(input logic [4:0] rv, input logic [3:0] av, input string tag);
    int         lat;
    logic [3:0] eb;
    logic       ee;
    model(int'(rv), int'(av), eb, ee);
    @(negedge clk);
    r = rv; a = av; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r = 5'($urandom);
    a = 4'($urandom);
    checkOutput({tag, ":busy_run"}, 32'(busy), 32'd1);
    wait_done(lat);
    checkOutput({tag, ":latency"}, 32'(lat), 32'd5);
    checkOutput({tag, ":b"}, 32'(b), 32'(eb));
    checkOutput({tag, ":err"}, 32'(err), 32'(ee));
    checkOutput({tag, ":busy_done"}, 32'(busy), 32'd1);
`ifdef SPLIT_RECHECK_EN
    checkOutput({tag, ":match"}, 32'(match), 32'(!ee));
`endif
    @(posedge clk); #1;
    checkOutput({tag, ":done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, ":busy_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, ":b_hold"}, 32'(b), 32'(eb));
  endtask

  initial begin
    int         lat;
    int         cnt_done;
    logic [3:0] eb;
    logic       ee;
    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    r        = '0;
    a        = '0;
    rst_n    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset:busy", 32'(busy), 32'd0);
    checkOutput("reset:done", 32'(done), 32'd0);
    checkOutput("reset:b", 32'(b), 32'd0);
    checkOutput("reset:err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(5'b01001, 4'b0011, "basic");
    applyStimulus(5'b11110, 4'b1111, "max_ok");
    applyStimulus(5'b00000, 4'b0000, "zero");
    applyStimulus(5'b00010, 4'b0101, "underflow");
    applyStimulus(5'b11111, 4'b0000, "overflow");

    for (int i = 0; i < 12; i++) begin
      applyStimulus(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
    end

    // Start pulsed mid-run with different operands must be ignored.
    @(negedge clk);
    r = 5'd5; a = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    r = 5'd31; a = 4'd31 & 4'hF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    checkOutput("busy_start:latency", 32'(lat + 2), 32'd5);
    checkOutput("busy_start:b", 32'(b), 32'd3);
    checkOutput("busy_start:err", 32'(err), 32'd0);
    cnt_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
    end
    checkOutput("busy_start:extra_done", 32'(cnt_done), 32'd0);

    // Start held high: back-to-back operations every 7 cycles.
    model(20, 7, eb, ee);
    @(negedge clk);
    r = 5'd20; a = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat);
    checkOutput("held:latency1", 32'(lat), 32'd5);
    checkOutput("held:b1", 32'(b), 32'(eb));
    wait_done(lat);
    start = 1'b0;
    checkOutput("held:interval", 32'(lat), 32'd7);
    checkOutput("held:b2", 32'(b), 32'(eb));
    checkOutput("held:err2", 32'(err), 32'(ee));
    repeat (2) @(posedge clk);

    // Reset during the third RUN cycle discards the operation.
    @(negedge clk);
    r = 5'd9; a = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    checkOutput("midreset:busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset:busy", 32'(busy), 32'd0);
    checkOutput("midreset:done", 32'(done), 32'd0);
    checkOutput("midreset:b", 32'(b), 32'd0);
    checkOutput("midreset:err", 32'(err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) cnt_done++;
    end
    checkOutput("midreset:no_done", 32'(cnt_done), 32'd0);
    applyStimulus(5'b01001, 4'b0011, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
